// File: rtl/ysyx_24080006_mdu_seq_pkg.sv
// ysyx_24080006_pkg: shared types for the iterative RV32M multiply/divide sequencer.
package ysyx_24080006_pkg;
    typedef enum logic [1:0] {MULL, MULH, DIV, REM} mdu_op_t;
    typedef struct packed {
        logic    mdu_enable;
        logic    signed_a;
        logic    signed_b;
        mdu_op_t mdu_op;
    } mdu_set_t;
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} mdu_state_t;
endpackage

// File: rtl/ysyx_24080006_mdu_seq_if.sv
// ysyx_24080006_mdu_seq_if: request/response handshake between EXU (master) and the MDU (slave).
interface ysyx_24080006_mdu_seq_if import ysyx_24080006_pkg::*; #(parameter int XLEN = 32);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    mdu_set_t        mdu_set;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;
    modport master (
        output flush, in_valid, mdu_set, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, busy
    );
    modport slave (
        input  flush, in_valid, mdu_set, src_a, src_b, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/ysyx_24080006_mdu_seq.sv
// ysyx_24080006_mdu_seq: radix-2 shift-add multiply / restoring divide over XLEN cycles,
// one shared adder/subtractor, sign fix-up in a final cycle.
module ysyx_24080006_mdu_seq import ysyx_24080006_pkg::*; #(
    parameter int XLEN      = 32,
    parameter bit FAST_SPEC = 1'b1
) (
    input logic                      clock,
    input logic                      reset_n,
    ysyx_24080006_mdu_seq_if.slave   mdu
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_t        r_state;
    logic [CW-1:0]     r_cnt;
    logic [2*XLEN:0]   r_acc;
    logic [XLEN-1:0]   r_div;
    mdu_op_t           r_op;
    logic              r_neg;
    logic [XLEN-1:0]   r_result;

    logic              w_accept, w_sa, w_sb, w_is_div, w_dz, w_ovf, w_fast, w_neg;
    logic [XLEN-1:0]   w_abs_a, w_abs_b, w_spec_res;
    logic              w_mul, w_sub, w_ge;
    logic [XLEN:0]     w_x;
    logic [XLEN-1:0]   w_y;
    logic [XLEN+1:0]   w_sum;
    logic [2*XLEN:0]   w_acc_nx;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_rem, w_fix_res;

    assign mdu.in_ready  = (r_state == IDLE) & ~mdu.flush;
    assign mdu.out_valid = (r_state == DONE);
    assign mdu.busy      = (r_state != IDLE);
    assign mdu.result    = r_result;

    always_comb begin
        w_accept   = mdu.in_valid & mdu.mdu_set.mdu_enable & mdu.in_ready;
        w_sa       = mdu.mdu_set.signed_a & mdu.src_a[XLEN-1];
        w_sb       = mdu.mdu_set.signed_b & mdu.src_b[XLEN-1];
        w_abs_a    = w_sa ? -mdu.src_a : mdu.src_a;
        w_abs_b    = w_sb ? -mdu.src_b : mdu.src_b;
        w_is_div   = (mdu.mdu_set.mdu_op == DIV) | (mdu.mdu_set.mdu_op == REM);
        w_dz       = w_is_div & (mdu.src_b == '0);
        w_ovf      = w_is_div & mdu.mdu_set.signed_a & mdu.mdu_set.signed_b &
                     (mdu.src_a == MIN_NEG) & (mdu.src_b == '1);
        w_fast     = FAST_SPEC & (w_dz | w_ovf);
        w_spec_res = w_dz ? ((mdu.mdu_set.mdu_op == DIV) ? '1 : mdu.src_a)
                          : ((mdu.mdu_set.mdu_op == DIV) ? mdu.src_a : '0);
        // Suppressing the quotient sign on /0 lets the slow path yield all-ones and REM=src_a naturally
        w_neg      = (mdu.mdu_set.mdu_op == REM) ? w_sa : (w_sa ^ w_sb) & ~w_dz;
    end

    always_comb begin
        w_mul    = (r_op == MULL) | (r_op == MULH);
        w_sub    = ~w_mul;
        w_x      = w_mul ? r_acc[2*XLEN:XLEN] : r_acc[2*XLEN-1:XLEN-1];
        w_y      = (w_mul & ~r_acc[0]) ? '0 : r_div;
        w_sum    = {1'b0, w_x} + ({2'b00, w_y} ^ {(XLEN+2){w_sub}}) + (XLEN+2)'(w_sub);
        w_ge     = ~w_sum[XLEN+1];
        w_acc_nx = w_mul ? {1'b0, w_sum[XLEN:0], r_acc[XLEN-1:1]}
                         : {w_ge ? w_sum[XLEN:0] : w_x, r_acc[XLEN-2:0], w_ge};
        w_prod    = r_neg ? -r_acc[2*XLEN-1:0] : r_acc[2*XLEN-1:0];
        w_rem     = r_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
        w_fix_res = (r_op == MULH) ? w_prod[2*XLEN-1:XLEN] :
                    (r_op == REM)  ? w_rem : w_prod[XLEN-1:0];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_div    <= '0;
            r_op     <= MULL;
            r_neg    <= 1'b0;
            r_result <= '0;
        end else if (mdu.flush) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_op    <= mdu.mdu_set.mdu_op;
                    r_neg   <= w_neg;
                    r_div   <= w_abs_b;
                    r_acc   <= {{(XLEN+1){1'b0}}, w_abs_a};
                    r_cnt   <= '0;
                    r_state <= w_fast ? DONE : CALC;
                    if (w_fast) r_result <= w_spec_res;
                end
                CALC: begin
                    r_acc <= w_acc_nx;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(XLEN-1)) r_state <= FIX;
                end
                FIX: begin
                    r_result <= w_fix_res;
                    r_state  <= DONE;
                end
                DONE: if (mdu.out_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_24080006_mdu_seq.sv
// tb_ysyx_24080006_mdu_seq: directed vectors into a scoreboard queue; a monitor checks result and latency.
module tb_ysyx_24080006_mdu_seq;
    import ysyx_24080006_pkg::*;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          t0;
        string       name;
    } exp_t;

    logic   clock = 1'b0;
    logic   reset_n = 1'b0;
    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;
    bit     seen = 1'b0;
    exp_t   q[$];

    ysyx_24080006_mdu_seq_if m();

    ysyx_24080006_mdu_seq dut (
        .clock   (clock),
        .reset_n (reset_n),
        .mdu     (m.slave)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: latency on first sight of out_valid, result on handshake
    always @(negedge clock) begin
        if (reset_n && m.out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_out_valid", 32'(m.out_valid), 32'd0);
            end else begin
                if (!seen) begin
                    chk({q[0].name, "_latency"}, 32'(cyc - q[0].t0), 32'(q[0].lat));
                    seen = 1'b1;
                end
                if (m.out_ready) begin
                    chk(q[0].name, m.result, q[0].res);
                    void'(q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic issue(input string name, input mdu_op_t op, input logic sa, input logic sb,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                         input int lat, input bit push);
        int n = 0;
        @(negedge clock);
        while (!m.in_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!m.in_ready) chk({name, "_ready_timeout"}, 32'(m.in_ready), 32'd1);
        m.in_valid = 1'b1;
        m.mdu_set  = '{mdu_enable: 1'b1, signed_a: sa, signed_b: sb, mdu_op: op};
        m.src_a    = a;
        m.src_b    = b;
        if (push) q.push_back('{res: res, lat: lat, t0: cyc, name: name});
        @(posedge clock);
        #1;
        m.in_valid = 1'b0;
        m.mdu_set  = '{mdu_enable: 1'b1, signed_a: ~sa, signed_b: ~sb, mdu_op: MULH};
        m.src_a    = $urandom;
        m.src_b    = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    initial begin
        int n;
        m.flush     = 1'b0;
        m.in_valid  = 1'b0;
        m.mdu_set   = '0;
        m.src_a     = '0;
        m.src_b     = '0;
        m.out_ready = 1'b1;
        #12;
        chk("rst_in_ready", 32'(m.in_ready), 32'd1);
        chk("rst_out_valid", 32'(m.out_valid), 32'd0);
        chk("rst_busy", 32'(m.busy), 32'd0);
        chk("rst_result", m.result, 32'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;

        issue("mul_7_m3",      MULL, 1, 1, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, 1);
        issue("mulh_min_min",  MULH, 1, 1, 32'h80000000, 32'h80000000, 32'h40000000, 34, 1);
        issue("mulhu_min_min", MULH, 0, 0, 32'h80000000, 32'h80000000, 32'h40000000, 34, 1);
        issue("mulhsu_m1_2",   MULH, 1, 0, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34, 1);
        issue("div_m7_2",      DIV,  1, 1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 1);
        issue("rem_m7_2",      REM,  1, 1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 1);
        issue("divu_max_16",   DIV,  0, 0, 32'hFFFFFFFF, 32'd16,       32'h0FFFFFFF, 34, 1);
        issue("div_100_0",     DIV,  1, 1, 32'd100,      32'd0,        32'hFFFFFFFF, 1,  1);
        issue("div_m100_0",    DIV,  1, 1, 32'hFFFFFF9C, 32'd0,        32'hFFFFFFFF, 1,  1);
        issue("rem_5_0",       REM,  1, 1, 32'd5,        32'd0,        32'd5,        1,  1);
        issue("rem_m5_0",      REM,  1, 1, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1,  1);
        issue("div_ovf",       DIV,  1, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  1);
        issue("rem_ovf",       REM,  1, 1, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  1);
        issue("divu_min_max",  DIV,  0, 0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        34, 1);
        issue("mulu_shift",    MULL, 0, 0, 32'h12345678, 32'h00000100, 32'h34567800, 34, 1);
        issue("mulhu_max_max", MULH, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 1);
        issue("mul_m1_m1",     MULL, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        34, 1);
        issue("div_100_7",     DIV,  1, 1, 32'd100,      32'd7,        32'd14,       34, 1);
        issue("rem_100_m7",    REM,  1, 1, 32'd100,      32'hFFFFFFF9, 32'd2,        34, 1);
        issue("remu_max_10",   REM,  0, 0, 32'hFFFFFFFF, 32'd10,       32'd5,        34, 1);
        drain();

        // Consumer back-pressure in DONE
        @(posedge clock);
        #1 m.out_ready = 1'b0;
        issue("stall_mul", MULL, 0, 0, 32'd3, 32'd5, 32'd15, 34, 1);
        n = 0;
        while (!m.out_valid && n < 100) begin
            @(negedge clock);
            n++;
        end
        repeat (5) begin
            chk("stall_result", m.result, 32'd15);
            chk("stall_in_ready", 32'(m.in_ready), 32'd0);
            @(negedge clock);
        end
        @(posedge clock);
        #1 m.out_ready = 1'b1;
        drain();

        // Flush mid-CALC at cnt=10
        issue("flush_op", MULL, 0, 0, 32'd123, 32'd456, 32'd0, 0, 0);
        repeat (10) @(posedge clock);
        #1 m.flush = 1'b1;
        @(negedge clock);
        chk("flush_in_ready", 32'(m.in_ready), 32'd0);
        @(posedge clock);
        #1 m.flush = 1'b0;
        @(negedge clock);
        chk("flush_busy", 32'(m.busy), 32'd0);
        chk("flush_out_valid", 32'(m.out_valid), 32'd0);
        chk("flush_in_ready_after", 32'(m.in_ready), 32'd1);
        repeat (40) @(negedge clock);
        issue("after_flush", MULL, 1, 1, 32'd6, 32'd7, 32'd42, 34, 1);
        drain();

        // mdu_enable low: request ignored
        @(negedge clock);
        m.in_valid = 1'b1;
        m.mdu_set  = '{mdu_enable: 1'b0, signed_a: 1'b0, signed_b: 1'b0, mdu_op: MULL};
        @(posedge clock);
        #1 m.in_valid = 1'b0;
        @(negedge clock);
        chk("no_enable_busy", 32'(m.busy), 32'd0);

        // Async reset mid-op
        issue("rst_op", MULL, 0, 0, 32'd9, 32'd9, 32'd0, 0, 0);
        repeat (10) @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(m.in_ready), 32'd1);
        chk("midrst_out_valid", 32'(m.out_valid), 32'd0);
        chk("midrst_busy", 32'(m.busy), 32'd0);
        chk("midrst_result", m.result, 32'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (40) @(negedge clock);
        issue("post_reset", MULL, 0, 0, 32'd9, 32'd9, 32'd81, 34, 1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
